// File: rtl/pipe_accum_if.sv
// Data/control bundle between the multiplier result split and pipe_accum.
// The master drives the addend and controls; the slave returns the running sum.
interface pipe_accum_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] accum_input;
  logic             accum_en;
  logic             accum_clear;
  logic [WIDTH-1:0] accum_output;
  logic             accum_valid;

  modport master (
    output accum_input,
    output accum_en,
    output accum_clear,
    input  accum_output,
    input  accum_valid
  );

  modport slave (
    input  accum_input,
    input  accum_en,
    input  accum_clear,
    output accum_output,
    output accum_valid
  );
endinterface

// File: rtl/pipe_accum.sv
// Pipelined running accumulator: the adder is cut into STAGES slices with registered
// carries, inputs are skewed into the slices and the sum is deskewed at the output.
module pipe_accum #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 4
) (
  input  logic        clock,
  input  logic        reset,
  pipe_accum_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0] enPipe_q;
  logic [STAGES-2:0] clrPipe_q;
  logic [WIDTH-1:0]  outSum_q;
  logic              valid_q;
  wire  [WIDTH-1:0]  outSum_d;
  wire  [STAGES-2:0] carryOut;

  // Enable and clear travel alongside the addend slices; valid is the enable
  // that has walked the whole pipe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enPipe_q  <= '0;
      clrPipe_q <= '0;
      outSum_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      enPipe_q     <= {enPipe_q[STAGES-2:0], bus.accum_en};
      clrPipe_q[0] <= bus.accum_clear;
      for (int i = 1; i < STAGES - 1; i++) begin
        clrPipe_q[i] <= clrPipe_q[i-1];
      end
      outSum_q <= outSum_d;
      valid_q  <= enPipe_q[STAGES-1];
    end
  end

  assign bus.accum_output = outSum_q;
  assign bus.accum_valid  = valid_q;

  for (genvar k = 0; k < STAGES; k++) begin : gSlice
    logic [SW-1:0] inK;
    logic          enK;
    logic          clrK;
    logic          cinK;
    logic [SW-1:0] base;
    logic [SW-1:0] add;
    logic [SW-1:0] sum_d;
    logic [SW-1:0] sum_q;

    if (k == 0) begin : gHead
      assign inK  = bus.accum_input[SW-1:0];
      assign enK  = bus.accum_en;
      assign clrK = bus.accum_clear;
      assign cinK = 1'b0;
    end else begin : gSkew
      logic [SW-1:0] inSkew_q [k];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < k; i++) begin
            inSkew_q[i] <= '0;
          end
        end else begin
          inSkew_q[0] <= bus.accum_input[k*SW +: SW];
          for (int i = 1; i < k; i++) begin
            inSkew_q[i] <= inSkew_q[i-1];
          end
        end
      end

      assign inK  = inSkew_q[k-1];
      assign enK  = enPipe_q[k-1];
      assign clrK = clrPipe_q[k-1];
      assign cinK = carryOut[k-1];
    end

    // A clear drops the old slice value but keeps the incoming carry, which
    // belongs to the same transaction as the clear.
    assign base = clrK ? '0 : sum_q;
    assign add  = enK ? inK : '0;

    if (k < STAGES - 1) begin : gCarry
      logic [SW:0] total;
      logic        carry_q;

      assign total = {1'b0, base} + {1'b0, add} + {{SW{1'b0}}, cinK};
      assign sum_d = total[SW-1:0];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          carry_q <= 1'b0;
        end else begin
          carry_q <= total[SW];
        end
      end

      assign carryOut[k] = carry_q;
    end else begin : gTop
      assign sum_d = base + add + {{(SW-1){1'b0}}, cinK};
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sum_q <= '0;
      end else begin
        sum_q <= sum_d;
      end
    end

    if (k == STAGES - 1) begin : gNoDeskew
      assign outSum_d[k*SW +: SW] = sum_q;
    end else begin : gDeskew
      logic [SW-1:0] deskew_q [STAGES-1-k];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < STAGES - 1 - k; i++) begin
            deskew_q[i] <= '0;
          end
        end else begin
          deskew_q[0] <= sum_q;
          for (int i = 1; i < STAGES - 1 - k; i++) begin
            deskew_q[i] <= deskew_q[i-1];
          end
        end
      end

      assign outSum_d[k*SW +: SW] = deskew_q[STAGES-2-k];
    end
  end
endmodule

// File: tb/tb_pipe_accum.sv
// Self-checking bench for pipe_accum: directed scenarios plus random traffic
// against a running-sum model delayed by a fixed-latency queue.
module tb_pipe_accum;
  localparam int WIDTH   = 24;
  localparam int LATENCY = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  pipe_accum_if #(.WIDTH(WIDTH)) bus ();

  pipe_accum #(.WIDTH(WIDTH), .STAGES(LATENCY)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] modelSum;
  logic [WIDTH:0]   expQ [$];

  // Reference: the result of a transaction is simply the wrapped running sum,
  // visible LATENCY edges later; the queue holds what has not emerged yet.
  function automatic void modelReset();
    modelSum = '0;
    expQ.delete();
    for (int i = 0; i < LATENCY; i++) expQ.push_back('0);
  endfunction

  task automatic step(input logic [WIDTH-1:0] din, input logic en, input logic clr,
                      output logic [WIDTH-1:0] expSum, output logic expValid);
    bus.accum_input = din;
    bus.accum_en    = en;
    bus.accum_clear = clr;
    @(posedge clock);
    if (clr) modelSum = '0;
    if (en)  modelSum = modelSum + din;
    expQ.push_back({en, modelSum});
    #1;
    {expValid, expSum} = expQ.pop_front();
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] es;
    logic             ev;
    reset = 1'b1;
    bus.accum_input = '0;
    bus.accum_en    = 1'b0;
    bus.accum_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      vectors++;
      if (bus.accum_output !== '0 || bus.accum_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold[%0d]: got sum=%h valid=%b, expected sum=000000 valid=0",
                 i, bus.accum_output, bus.accum_valid);
      end
    end
    #3 reset = 1'b0;
    modelReset();
    for (int i = 0; i < 10; i++) begin
      step(WIDTH'($urandom), 1'b0, 1'b0, es, ev);
      vectors++;
      if (bus.accum_output !== 24'h000000 || bus.accum_valid !== 1'b0 ||
          bus.accum_output !== es || bus.accum_valid !== ev) begin
        miscompares++;
        $display("[TB] FAIL idle[%0d]: got sum=%h valid=%b, expected sum=000000 valid=0",
                 i, bus.accum_output, bus.accum_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ins    [4] = '{24'h1, 24'h2, 24'h3, 24'h4};
    logic [WIDTH-1:0] want   [4] = '{24'h000001, 24'h000003, 24'h000006, 24'h00000A};
    logic [WIDTH-1:0] gotSum [8];
    logic             gotVal [8];
    logic [WIDTH-1:0] es;
    logic             ev;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(ins[i], 1'b1, i == 0, es, ev);
      else       step(WIDTH'($urandom), 1'b0, 1'b0, es, ev);
      gotSum[i] = bus.accum_output;
      gotVal[i] = bus.accum_valid;
      vectors++;
      if (gotSum[i] !== es || gotVal[i] !== ev) begin
        miscompares++;
        $display("[TB] FAIL b2b_model[%0d]: got sum=%h valid=%b, expected sum=%h valid=%b",
                 i, gotSum[i], gotVal[i], es, ev);
      end
    end
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (gotSum[4+j] !== want[j] || gotVal[4+j] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_sum[%0d]: got sum=%h valid=%b, expected sum=%h valid=1",
                 j, gotSum[4+j], gotVal[4+j], want[j]);
      end
    end
  endtask

  task automatic test_carry_wrap();
    logic [WIDTH-1:0] ins    [6] = '{24'h00003F, 24'h000001, 24'hFFFFFF, 24'h000001, 24'h000005, 24'hFFFFFF};
    logic             clrs   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [WIDTH-1:0] want   [6] = '{24'h00003F, 24'h000040, 24'hFFFFFF, 24'h000000, 24'h000005, 24'h000004};
    logic [WIDTH-1:0] gotSum [10];
    logic [WIDTH-1:0] es;
    logic             ev;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) step(ins[i], 1'b1, clrs[i], es, ev);
      else       step(WIDTH'($urandom), 1'b0, 1'b0, es, ev);
      gotSum[i] = bus.accum_output;
      vectors++;
      if (bus.accum_output !== es || bus.accum_valid !== ev) begin
        miscompares++;
        $display("[TB] FAIL carry_model[%0d]: got sum=%h valid=%b, expected sum=%h valid=%b",
                 i, bus.accum_output, bus.accum_valid, es, ev);
      end
    end
    for (int j = 0; j < 6; j++) begin
      vectors++;
      if (gotSum[4+j] !== want[j]) begin
        miscompares++;
        $display("[TB] FAIL carry_sum[%0d]: got sum=%h, expected sum=%h", j, gotSum[4+j], want[j]);
      end
    end
  endtask

  task automatic test_clear_mid();
    logic [WIDTH-1:0] ins    [4] = '{24'h123456, 24'h000010, 24'h000001, 24'h000ABC};
    logic             ens    [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic             clrs   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [WIDTH-1:0] want   [4] = '{24'h123456, 24'h000010, 24'h000011, 24'h000000};
    logic             wantV  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [WIDTH-1:0] gotSum [8];
    logic             gotVal [8];
    logic [WIDTH-1:0] es;
    logic             ev;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(ins[i], ens[i], clrs[i], es, ev);
      else       step(WIDTH'($urandom), 1'b0, 1'b0, es, ev);
      gotSum[i] = bus.accum_output;
      gotVal[i] = bus.accum_valid;
      vectors++;
      if (gotSum[i] !== es || gotVal[i] !== ev) begin
        miscompares++;
        $display("[TB] FAIL clear_model[%0d]: got sum=%h valid=%b, expected sum=%h valid=%b",
                 i, gotSum[i], gotVal[i], es, ev);
      end
    end
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (gotSum[4+j] !== want[j] || gotVal[4+j] !== wantV[j]) begin
        miscompares++;
        $display("[TB] FAIL clear_sum[%0d]: got sum=%h valid=%b, expected sum=%h valid=%b",
                 j, gotSum[4+j], gotVal[4+j], want[j], wantV[j]);
      end
    end
  endtask

  task automatic test_enable_gaps();
    logic [WIDTH-1:0] ins    [4] = '{24'h000FFF, 24'h5A5A5A, 24'hA5A5A5, 24'h000001};
    logic             ens    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic             clrs   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [WIDTH-1:0] want   [4] = '{24'h000FFF, 24'h000FFF, 24'h000FFF, 24'h001000};
    logic             wantV  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] gotSum [8];
    logic             gotVal [8];
    logic [WIDTH-1:0] es;
    logic             ev;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(ins[i], ens[i], clrs[i], es, ev);
      else       step(WIDTH'($urandom), 1'b0, 1'b0, es, ev);
      gotSum[i] = bus.accum_output;
      gotVal[i] = bus.accum_valid;
      vectors++;
      if (gotSum[i] !== es || gotVal[i] !== ev) begin
        miscompares++;
        $display("[TB] FAIL gaps_model[%0d]: got sum=%h valid=%b, expected sum=%h valid=%b",
                 i, gotSum[i], gotVal[i], es, ev);
      end
    end
    for (int j = 0; j < 4; j++) begin
      vectors++;
      if (gotSum[4+j] !== want[j] || gotVal[4+j] !== wantV[j]) begin
        miscompares++;
        $display("[TB] FAIL gaps_sum[%0d]: got sum=%h valid=%b, expected sum=%h valid=%b",
                 j, gotSum[4+j], gotVal[4+j], want[j], wantV[j]);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [WIDTH-1:0] es;
    logic             ev;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)     step(24'h00007F, 1'b1, 1'b1, es, ev);
      else if (i < 5) step(WIDTH'($urandom), 1'b0, 1'b0, es, ev);
      else            step(24'h000001, 1'b1, 1'b0, es, ev);
      vectors++;
      if (bus.accum_output !== es || bus.accum_valid !== ev) begin
        miscompares++;
        $display("[TB] FAIL midrst_pre[%0d]: got sum=%h valid=%b, expected sum=%h valid=%b",
                 i, bus.accum_output, bus.accum_valid, es, ev);
      end
    end
    bus.accum_en = 1'b0;
    bus.accum_clear = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (bus.accum_output !== '0 || bus.accum_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: got sum=%h valid=%b, expected sum=000000 valid=0",
               bus.accum_output, bus.accum_valid);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      vectors++;
      if (bus.accum_output !== '0 || bus.accum_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL midrst_hold[%0d]: got sum=%h valid=%b, expected sum=000000 valid=0",
                 i, bus.accum_output, bus.accum_valid);
      end
    end
    #2 reset = 1'b0;
    modelReset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(24'h000007, 1'b1, 1'b1, es, ev);
      else        step(WIDTH'($urandom), 1'b0, 1'b0, es, ev);
      vectors++;
      if (bus.accum_output !== es || bus.accum_valid !== ev) begin
        miscompares++;
        $display("[TB] FAIL midrst_post[%0d]: got sum=%h valid=%b, expected sum=%h valid=%b",
                 i, bus.accum_output, bus.accum_valid, es, ev);
      end
    end
    vectors++;
    if (bus.accum_output !== 24'h000007 || bus.accum_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_load: got sum=%h valid=%b, expected sum=000007 valid=1",
               bus.accum_output, bus.accum_valid);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] es;
    logic             ev;
    logic [WIDTH-1:0] din;
    for (int i = 0; i < 300; i++) begin
      din = ($urandom_range(0, 7) == 0) ? WIDTH'(24'hFFFFFF - $urandom_range(0, 3)) : WIDTH'($urandom);
      step(din, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, es, ev);
      vectors++;
      if (bus.accum_output !== es || bus.accum_valid !== ev) begin
        miscompares++;
        $display("[TB] FAIL random[%0d]: got sum=%h valid=%b, expected sum=%h valid=%b",
                 i, bus.accum_output, bus.accum_valid, es, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_carry_wrap();
    test_clear_mid();
    test_enable_gaps();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/pipe_accum.md
# pipe_accum

Pipelined 24-bit running accumulator on the multiply-accumulate path, placed between the multiplier result split and the result resync stage. It consumes the 24-bit data field of the multiplier output and returns the running sum. Its latency is exactly 4 cycles, matching the 4-cycle delay applied to the multiplier's bit-24 flag in the resync stage. The adder is split into 6-bit slices with registered carries so the 24-bit feedback loop never exceeds one slice per cycle.

## Interface
- WIDTH, 24, accumulator and data width; must be divisible by STAGES
- STAGES, 4, number of carry slices; also the latency in cycles; slice width SW = WIDTH/STAGES (6)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears every register
- accum_input  input  WIDTH  addend; sampled every edge
- accum_en  input  1  1: add accum_input; 0: add zero (carries still drain)
- accum_clear  input  1  1: discard the prior sum, so the result is this cycle's addend (or 0 if accum_en=0)
- accum_output  output  WIDTH  running sum, modulo 2^WIDTH
- accum_valid  output  1  accum_en delayed by STAGES cycles

## Operation
- Slice k (k = 0..STAGES-1) owns sum bits [k*SW+SW-1 : k*SW].
- Input skew: addend slice k, effective-enable and clear each pass through k registers before reaching slice k.
- Slice k update at its edge:
  - sum_k <= (clear_k ? 0 : sum_k) + (en_k ? in_k : 0) + cin_k
  - cin_k is the registered carry-out of slice k-1 from its previous update; cin_0 = 0.
  - The carry-out of the top slice is discarded, so the sum wraps modulo 2^WIDTH.
- On clear, slice k zeroes its old value but still adds cin_k. That carry belongs to the same transaction, because the skewed clear arrives in the same cycle as the carry.
- Output deskew: slice k passes through STAGES-1-k registers, then one common output register drives accum_output.
- Arithmetic is bit-identical for two's complement and unsigned; no saturation and no overflow flag.
- No stall: a transaction enters every cycle. Idle cycles use accum_en=0.

## Timing
- Reset (async assert, sync release by the system): all slice sums, skew/deskew registers, carries, accum_output and accum_valid are 0.
- Latency: inputs sampled at edge N appear on accum_output/accum_valid after edge N+4 (for STAGES=4).
- Throughput: 1 transaction per cycle. Back-to-back adds are exact with no bubbles.
- Simultaneous accum_clear=1 and accum_en=1: the result equals accum_input.
- accum_clear=1 with accum_en=0: the result is 0.
- Reset mid-operation: all in-flight transactions are lost. Outputs are 0 until 4 cycles after the first post-reset transaction.
- Outputs change only on clock edges or reset. There is no combinational path from input to output.

## Test plan
- Reset then idle: hold reset 3 cycles, then accum_en=0 for 10 cycles -> accum_output=0x000000 and accum_valid=0 throughout.
- Back-to-back adds: clear+load 0x000001 at edge N, then add 2, 3, 4 at N+1..N+3 -> accum_output = 0x000001, 0x000003, 0x000006, 0x00000A after edges N+4..N+7; accum_valid=1 on each.
- Carry ripple and wrap:
  - clear+load 0x00003F, then add 0x000001 -> 0x000040.
  - clear+load 0xFFFFFF, then add 0x000001 -> 0x000000.
  - Add 0xFFFFFF (-1) to 0x000005 -> 0x000004.
- Clear mid-stream: running sum 0x123456, then clear+load 0x000010 at edge M, then add 0x000001 at M+1 -> 0x000010 after M+4, 0x000011 after M+5.
- Enable gaps: add 0x000FFF, then accum_en=0 for 2 cycles, then add 0x000001 -> outputs 0x000FFF, 0x000FFF, 0x000FFF, 0x001000; accum_valid = 1, 0, 0, 1.
- Reset mid-operation: assert reset asynchronously between edges while 3 transactions are in flight -> accum_output and accum_valid go to 0 immediately. After release, clear+load 0x000007 -> 0x000007 after 4 edges.
